// File: rtl/tick_period_meter_pkg.sv
// rtl/tick_period_meter_pkg.sv - shared state encoding and defaults for the tick period meter
package tick_period_meter_pkg;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

    localparam int DEFAULT_N_BIT = 16;

endpackage

// File: rtl/tick_period_meter_sat_counter.sv
// rtl/tick_period_meter_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int N_BIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [N_BIT-1:0] cnt_o,
    output logic             sat_o
);

    logic [N_BIT-1:0] cnt_q;

    // Clear wins over increment; the count sticks at all-ones once reached.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !sat_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = &cnt_q;

endmodule

// File: rtl/tick_period_meter.sv
// rtl/tick_period_meter.sv - recovers the divide value N of a tick stream, with lock and overflow flags
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int N_BIT    = DEFAULT_N_BIT,
    parameter int LOCK_CNT = 4
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick_in,
    output logic [N_BIT-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             overflow
);

    localparam int M_W = $clog2(LOCK_CNT + 1);
    localparam logic [M_W-1:0] LOCK_MAX = M_W'(LOCK_CNT);

    state_t           state_q;
    logic             discard_q;
    logic [M_W-1:0]   match_q;
    logic [M_W-1:0]   match_d;
    logic [N_BIT-1:0] period_q;
    logic             valid_q;
    logic             locked_q;
    logic             overflow_q;

    logic             ev;
    logic             cnt_inc;
    logic [N_BIT-1:0] cnt;
    logic             cnt_sat;

    assign ev      = enable & tick_in;
    assign cnt_inc = enable & ~tick_in & (state_q == MEASURE);

    sat_counter #(
        .N_BIT (N_BIT)
    ) u_cnt (
        .clk_i (clkin),
        .rst_i (rst),
        .clr_i (ev),
        .inc_i (cnt_inc),
        .cnt_o (cnt),
        .sat_o (cnt_sat)
    );

    // A zero match count means there is no previous period to compare against.
    always_comb begin
        match_d = M_W'(1);
        if (match_q != '0 && cnt == period_q) begin
            match_d = (match_q == LOCK_MAX) ? LOCK_MAX : match_q + M_W'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q    <= WAIT_FIRST;
            discard_q  <= 1'b0;
            match_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (enable) begin
                case (state_q)
                    WAIT_FIRST: begin
                        if (tick_in) begin
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (tick_in) begin
                            if (discard_q) begin
                                discard_q <= 1'b0;
                            end else begin
                                period_q   <= cnt;
                                valid_q    <= 1'b1;
                                overflow_q <= 1'b0;
                                match_q    <= match_d;
                                locked_q   <= (match_d == LOCK_MAX);
                            end
                        end else if (cnt_sat) begin
                            // Gap too long to measure: the closing event is dropped.
                            overflow_q <= 1'b1;
                            locked_q   <= 1'b0;
                            match_q    <= '0;
                            discard_q  <= 1'b1;
                        end
                    end
                    default: state_q <= WAIT_FIRST;
                endcase
            end
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// tb/tb_tick_period_meter.sv - directed and randomized bench for tick_period_meter at two counter widths
module tb_tick_period_meter;

    localparam int LOCK_CNT = 4;

    logic        clkin = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tick_in = 1'b0;

    logic [15:0] period16;
    logic        valid16, locked16, overflow16;
    logic [3:0]  period4;
    logic        valid4, locked4, overflow4;

    int checks = 0;
    int failures = 0;

    always #5 clkin = ~clkin;

    tick_period_meter #(.N_BIT(16), .LOCK_CNT(LOCK_CNT)) u_dut16 (
        .clkin    (clkin),
        .rst      (rst),
        .enable   (enable),
        .tick_in  (tick_in),
        .period   (period16),
        .valid    (valid16),
        .locked   (locked16),
        .overflow (overflow16)
    );

    tick_period_meter #(.N_BIT(4), .LOCK_CNT(LOCK_CNT)) u_dut4 (
        .clkin    (clkin),
        .rst      (rst),
        .enable   (enable),
        .tick_in  (tick_in),
        .period   (period4),
        .valid    (valid4),
        .locked   (locked4),
        .overflow (overflow4)
    );

    // Reference: elapsed enabled cycles since the last event, plus the history of valid periods.
    int max_cnt [2] = '{65535, 15};
    bit m_started [2];
    int m_gap [2];
    bit m_discard [2];
    int m_period [2];
    bit m_valid [2];
    bit m_locked [2];
    bit m_ovf [2];
    int hist0 [$];
    int hist1 [$];

    function automatic bit tail_equal(input int q [$]);
        if (q.size() < LOCK_CNT) return 1'b0;
        for (int i = q.size() - LOCK_CNT; i < q.size(); i++)
            if (q[i] != q[q.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model(input int d, input logic r, input logic en, input logic tk);
        m_valid[d] = 1'b0;
        if (r) begin
            m_started[d] = 0; m_gap[d] = 0; m_discard[d] = 0;
            m_period[d] = 0; m_locked[d] = 0; m_ovf[d] = 0;
            if (d == 0) hist0.delete(); else hist1.delete();
        end else if (en) begin
            if (tk) begin
                if (m_started[d]) begin
                    if (m_discard[d]) begin
                        m_discard[d] = 0;
                    end else begin
                        m_period[d] = m_gap[d];
                        m_valid[d] = 1'b1;
                        m_ovf[d] = 1'b0;
                        if (d == 0) begin
                            hist0.push_back(m_gap[d]);
                            m_locked[d] = tail_equal(hist0);
                        end else begin
                            hist1.push_back(m_gap[d]);
                            m_locked[d] = tail_equal(hist1);
                        end
                    end
                end
                m_started[d] = 1;
                m_gap[d] = 0;
            end else if (m_started[d]) begin
                m_gap[d] = m_gap[d] + 1;
                if (m_gap[d] > max_cnt[d]) begin
                    m_ovf[d] = 1'b1;
                    m_locked[d] = 1'b0;
                    m_discard[d] = 1'b1;
                    if (d == 0) hist0.delete(); else hist1.delete();
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic tk);
        rst = r;
        enable = en;
        tick_in = tk;
        @(posedge clkin);
        #1;
        model(0, r, en, tk);
        model(1, r, en, tk);
        check("valid16", {15'd0, valid16}, {15'd0, m_valid[0]});
        check("period16", period16, m_period[0][15:0]);
        check("locked16", {15'd0, locked16}, {15'd0, m_locked[0]});
        check("overflow16", {15'd0, overflow16}, {15'd0, m_ovf[0]});
        check("valid4", {15'd0, valid4}, {15'd0, m_valid[1]});
        check("period4", {12'd0, period4}, m_period[1][15:0]);
        check("locked4", {15'd0, locked4}, {15'd0, m_locked[1]});
        check("overflow4", {15'd0, overflow4}, {15'd0, m_ovf[1]});
    endtask

    task automatic gap(input int g);
        for (int i = 0; i < g - 1; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int mode;
        int per;
        int phase;

        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("reset_outputs", {valid16, locked16, overflow16, period16[12:0]}, 16'd0);

        // Divide-by-10 stream: first event only arms, lock on the fifth event.
        step(1'b0, 1'b1, 1'b1);
        check("first_event_no_valid", {15'd0, valid16}, 16'd0);
        for (int i = 0; i < 3; i++) gap(10);
        check("not_yet_locked", {15'd0, locked16}, 16'd0);
        gap(10);
        check("locked_n9", {15'd0, locked16}, 16'd1);
        check("period_n9", period16, 16'd9);

        gap(8);
        check("short_gap_period", period16, 16'd7);
        check("short_gap_unlock", {15'd0, locked16}, 16'd0);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        check("tick_high_period", period16, 16'd0);
        check("tick_high_locked", {15'd0, locked16}, 16'd1);

        gap(20);
        check("ovf4_set", {15'd0, overflow4}, 16'd1);
        check("ovf4_no_valid", {15'd0, valid4}, 16'd0);
        check("wide_gap_period", period16, 16'd19);
        gap(5);
        check("ovf4_recover_period", {12'd0, period4}, 16'd4);
        check("ovf4_cleared", {15'd0, overflow4}, 16'd0);

        // Three frozen cycles with stray ticks inside a 10-cycle interval.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("freeze_period", period16, 16'd9);

        // Reset in the middle of an interval.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("midreset_outputs", {valid16, locked16, overflow16, period16[12:0]}, 16'd0);
        gap(3);
        check("midreset_no_valid", {15'd0, valid16}, 16'd0);
        gap(7);
        check("midreset_period", period16, 16'd6);

        // Randomized blocks: sparse ticks, periodic ticks, dense random ticks.
        per = 1;
        phase = 0;
        for (int b = 0; b < 12; b++) begin
            mode = b % 3;
            per = $urandom_range(1, 12);
            for (int c = 0; c < 120; c++) begin
                logic r, en, tk;
                r  = ($urandom_range(0, 299) == 0);
                en = ($urandom_range(0, 7) != 0);
                case (mode)
                    0:       tk = ($urandom_range(0, 24) == 0);
                    1:       tk = (phase % per == 0);
                    default: tk = ($urandom_range(0, 2) == 0);
                endcase
                if (en) phase++;
                step(r, en, tk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receiving end of the clock-tick interface: consumes a tick stream (as produced by the team's programmable tick divider) and recovers its programmed divide value N.
- Counts enabled clkin cycles between tick events and reports N = interval − 1, so feeding back the reported value reproduces the source rate.
- Flags lock when the period is stable and flags overflow when the gap exceeds the counter range.
- Sits beside the divider for self-check, and on the consumer side of any tick-paced datapath.

Parameters:
- N_BIT, 16, width of the period counter and of the period output.
- LOCK_CNT, 4, consecutive equal measurements required to assert locked; must be at least 2.

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  cycle qualifier; when low, the counter freezes and tick_in is ignored.
- tick_in  input  1  tick stream; every cycle with enable=1 and tick_in=1 is one event. No edge detection is applied.
- period  output  N_BIT  last valid measured N; held between updates.
- valid  output  1  one-cycle pulse when period updates.
- locked  output  1  high while the last LOCK_CNT valid periods were all equal.
- overflow  output  1  sticky; set when the counter saturates.

Behaviour:
- Reset and interface:
  - One clock. Reset is synchronous and active-high.
  - Reset forces state WAIT_FIRST, cnt=0, period=0, valid=0, locked=0, overflow=0, match count=0.
  - Reset asserted mid-interval discards the partial count. The first event after reset only starts timing.
- States:
  - WAIT_FIRST: on an event, go to MEASURE and set cnt=0. No valid is produced.
  - MEASURE, on each enabled non-event cycle: cnt increments by 1, saturating at 2^N_BIT−1.
  - MEASURE, when cnt is already at 2^N_BIT−1 and the cycle is a non-event: set overflow=1 and locked=0, clear the match count, and set an internal discard flag.
  - MEASURE, on an event:
    - If the discard flag is clear: period<=cnt, valid<=1, overflow<=0.
    - If the discard flag is set: no valid, and the discard flag clears.
    - In both cases cnt<=0 and the state stays MEASURE.
- Timing:
  - Events exactly N+1 enabled cycles apart produce cnt==N at the second event.
  - A tick held high every cycle yields period 0.
  - period and valid are registered and appear one cycle after the event cycle.
- Lock:
  - On each valid, if the new period equals the previous valid period, the match count increments, saturating at LOCK_CNT. Otherwise the match count is set to 1.
  - locked is registered with valid and is high iff the match count equals LOCK_CNT.
  - A mismatching valid drops locked in the same cycle valid rises.
  - The first valid after reset or after an overflow sets the match count to 1.
- enable=0:
  - No count, no events, state held, and all outputs held, except that valid returns to 0 after its pulse.
  - Frozen cycles are excluded from the interval.
- Simultaneous events:
  - An event on the saturating cycle is counted as an event, so no overflow.
  - rst overrides enable and tick_in.
- Width: period equals cnt directly, with no arithmetic beyond the increment. The match count is $clog2(LOCK_CNT+1) bits.

Decomposition:
- Shared package/header: state encodings WAIT_FIRST=1'b0 and MEASURE=1'b1, and the default N_BIT.
- One natural sub-module, sat_counter: an N_BIT-wide counter with synchronous clear, enable and a saturated output flag.
- Lock comparison and the FSM stay in the top module.

Test Plan:
- Divider with N=9, enable=1: events every 10 cycles.
  - No valid after the first event.
  - valid with period=9 one cycle after the 2nd event.
  - locked=1 with the 5th event's valid (4 equal periods).
- tick_in held high continuously: after the first event, valid every cycle with period=0. locked rises on the 4th valid.
- Locked at period 9, then the next gap is 8 cycles: valid with period=7, locked falls in the same cycle, match count resets to 1.
- N_BIT=4, gap of 20 cycles:
  - overflow=1 on the saturating cycle and locked=0.
  - The closing event gives no valid.
  - Next gap of 5 cycles: valid, period=4, overflow=0.
- Events 10 cycles apart with enable=0 for 3 cycles mid-interval: period=9, and tick_in pulses during enable=0 are ignored.
- rst for 1 cycle midway through an interval:
  - All outputs read 0 next cycle.
  - The next event gives no valid.
  - The following event gives the correct period.
